// File: rtl/led_scroller_pkg.sv
// ---------------------------------------------------------------------------
// led_scroller_pkg : shared types, direction codes and rotate helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package led_scroller_pkg;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Widest pattern rot1 can handle; LED_W must not exceed this.
  localparam int unsigned MAX_LED_W = 64;

  typedef enum logic [1:0] {
    SPD_X1 = 2'd0,
    SPD_X2 = 2'd1,
    SPD_X4 = 2'd2,
    SPD_X8 = 2'd3
  } speed_e;

  function automatic logic [MAX_LED_W-1:0] rot1(
    input logic [MAX_LED_W-1:0] pat,
    input logic                 dir,
    input int unsigned          w
  );
    logic [MAX_LED_W-1:0] mask;
    logic [MAX_LED_W-1:0] res;
    mask = {MAX_LED_W{1'b1}} >> (MAX_LED_W - w);
    if (dir == DIR_LEFT)
      res = (pat << 1) | ((pat >> (w - 1)) & MAX_LED_W'(1));
    else
      res = (pat >> 1) | ((pat & MAX_LED_W'(1)) << (w - 1));
    return res & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scroll_tick_gen.sv
// ---------------------------------------------------------------------------
// scroll_tick_gen : speed-selectable prescaler, one tick per step period
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module scroll_tick_gen
  import led_scroller_pkg::*;
#(
  parameter int unsigned CNT_1S = 100_000_000,
  parameter int unsigned CNT_W  = 27
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   en,
  input  logic   clr,
  input  speed_e speed,
  output logic   tick
);

  // One extra bit so CNT_1S == 2**CNT_W is representable.
  localparam logic [CNT_W:0] c_base = (CNT_W + 1)'(CNT_1S);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_period;
  logic [CNT_W:0]   w_limit;

  assign w_period = c_base >> speed;
  assign w_limit  = w_period - (CNT_W + 1)'(1);

  // >= rather than == so a speed change that drops the limit below the
  // running count wraps immediately instead of overrunning.
  assign tick = en && ({1'b0, r_cnt} >= w_limit);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (tick)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_scroller_ctrl.sv
// ---------------------------------------------------------------------------
// led_scroller_ctrl : rotating LED pattern engine with load, pause, speed
// Optional bounce mode when LED_SCROLLER_BOUNCE_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_scroller_ctrl
  import led_scroller_pkg::*;
#(
  parameter int unsigned           LED_W    = 16,
  parameter int unsigned           CNT_1S   = 100_000_000,
  parameter int unsigned           CNT_W    = 27,
  parameter logic [LED_W-1:0]      INIT_PAT = {{(LED_W-1){1'b1}}, 1'b0}
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       speed,
  input  logic             load,
  input  logic [LED_W-1:0] load_pat,
`ifdef LED_SCROLLER_BOUNCE_EN
  input  logic             bounce,
`endif
  output logic [LED_W-1:0] led,
  output logic             step
);

  logic             w_tick;
  logic             w_dir;
  logic [LED_W-1:0] w_rot;

  scroll_tick_gen #(
    .CNT_1S (CNT_1S),
    .CNT_W  (CNT_W)
  ) u_tick_gen (
    .clk    (clk),
    .resetn (resetn),
    .en     (en),
    .clr    (load),
    .speed  (speed_e'(speed)),
    .tick   (w_tick)
  );

  assign w_rot = LED_W'(rot1(MAX_LED_W'(led), w_dir, LED_W));

`ifdef LED_SCROLLER_BOUNCE_EN
  logic r_dir;

  assign w_dir = bounce ? r_dir : dir;

  // Flip when the freshly stepped pattern shows a dark LED at the leading edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dir <= DIR_LEFT;
    end else if (load || !bounce) begin
      r_dir <= dir;
    end else if (w_tick) begin
      if ((w_dir == DIR_LEFT) ? !w_rot[LED_W-1] : !w_rot[0])
        r_dir <= ~r_dir;
    end
  end
`else
  assign w_dir = dir;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led  <= INIT_PAT;
      step <= 1'b0;
    end else if (load) begin
      led  <= load_pat;
      step <= 1'b0;
    end else if (w_tick) begin
      led  <= w_rot;
      step <= 1'b1;
    end else begin
      step <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_scroller_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_scroller_ctrl : directed self-checking bench for led_scroller_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_led_scroller_ctrl;

  logic       clk      = 1'b0;
  logic       resetn   = 1'b0;
  logic       en       = 1'b0;
  logic       dir      = 1'b0;
  logic [1:0] speed    = 2'd0;
  logic       load     = 1'b0;
  logic [7:0] load_pat = 8'h00;
`ifdef LED_SCROLLER_BOUNCE_EN
  logic       bounce   = 1'b0;
`endif
  logic [7:0] led;
  logic       step;

  int tests = 0;
  int fails = 0;

  led_scroller_ctrl #(
    .LED_W    (8),
    .CNT_1S   (8),
    .CNT_W    (4),
    .INIT_PAT (8'hFE)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en),
    .dir      (dir),
    .speed    (speed),
    .load     (load),
    .load_pat (load_pat),
`ifdef LED_SCROLLER_BOUNCE_EN
    .bounce   (bounce),
`endif
    .led      (led),
    .step     (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [7:0] exp_led, input logic exp_step);
    chk({tag, "_led"}, led, exp_led);
    chk({tag, "_step"}, {7'd0, step}, {7'd0, exp_step});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    en = 1'b1;
    cyc(2);
    chk2("reset", 8'hFE, 1'b0);

    // first steps after release at cycles 8 and 16
    resetn = 1'b1;
    cyc(7);  chk2("t1_c7",  8'hFE, 1'b0);
    cyc(1);  chk2("t1_c8",  8'hFD, 1'b1);
    cyc(1);  chk2("t1_c9",  8'hFD, 1'b0);
    cyc(7);  chk2("t1_c16", 8'hFB, 1'b1);

    // speed 3: step every cycle
    speed = 2'd3;
    cyc(1);  chk2("t2_s3a", 8'hF7, 1'b1);
    cyc(1);  chk2("t2_s3b", 8'hEF, 1'b1);
    cyc(1);  chk2("t2_s3c", 8'hDF, 1'b1);
    cyc(1);  chk2("t2_s3d", 8'hBF, 1'b1);

    // speed 0 up to cnt=6, then speed 2 wraps next cycle, then period 2
    speed = 2'd0;
    cyc(6);  chk2("t2_cnt6", 8'hBF, 1'b0);
    speed = 2'd2;
    cyc(1);  chk2("t2_wrap", 8'h7F, 1'b1);
    cyc(1);  chk2("t2_p2a",  8'h7F, 1'b0);
    cyc(1);  chk2("t2_p2b",  8'hFE, 1'b1);

    // rotate right, then pause and resume
    dir   = 1'b1;
    speed = 2'd0;
    cyc(7);  chk2("t3_c7",   8'hFE, 1'b0);
    cyc(1);  chk2("t3_r1",   8'h7F, 1'b1);
    cyc(8);  chk2("t3_r2",   8'hBF, 1'b1);
    cyc(3);  chk2("t3_mid",  8'hBF, 1'b0);
    en = 1'b0;
    cyc(20); chk2("t3_frz",  8'hBF, 1'b0);
    en = 1'b1;
    cyc(4);  chk2("t3_res4", 8'hBF, 1'b0);
    cyc(1);  chk2("t3_res5", 8'hDF, 1'b1);

    // load coinciding with a tick wins and restarts the period
    dir = 1'b0;
    cyc(7);
    load     = 1'b1;
    load_pat = 8'hA5;
    cyc(1);  chk2("t4_load", 8'hA5, 1'b0);
    load = 1'b0;
    cyc(7);  chk2("t4_c7",   8'hA5, 1'b0);
    cyc(1);  chk2("t4_step", 8'h4B, 1'b1);

    // async reset right after a step clears step and led without a clock edge
    #1 resetn = 1'b0;
    #1 chk2("t5_rst_a", 8'hFE, 1'b0);
    cyc(1);
    resetn = 1'b1;
    cyc(3);
    #2 resetn = 1'b0;
    #1 chk2("t5_rst_b", 8'hFE, 1'b0);
    resetn = 1'b1;
    cyc(7);  chk2("t5_c7",   8'hFE, 1'b0);
    cyc(1);  chk2("t5_c8",   8'hFD, 1'b1);

    // load while paused, all-ones pattern rotates to itself and still steps
    en       = 1'b0;
    load     = 1'b1;
    load_pat = 8'hFF;
    cyc(1);  chk2("t6_ldff", 8'hFF, 1'b0);
    load  = 1'b0;
    en    = 1'b1;
    speed = 2'd3;
    cyc(1);  chk2("t6_rotff", 8'hFF, 1'b1);

`ifdef LED_SCROLLER_BOUNCE_EN
    begin
      logic [7:0] exp_seq [15];
      exp_seq = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F,
                  8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hFD};
      #1 resetn = 1'b0;
      dir    = 1'b0;
      bounce = 1'b1;
      cyc(1);
      resetn = 1'b1;
      for (int i = 0; i < 15; i++) begin
        cyc(1);
        chk2($sformatf("t7_bnc%0d", i), exp_seq[i], 1'b1);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
